// File: rtl/ga_pkg.sv
// ga_pkg: shared definitions for the GA generation sequencer.
//   - default population geometry (paths per population, bits per path)
//   - sequencer state codes (3-bit, visible on state_out)
//   - helpers: population width and "is this a supervised stage" test
package ga_pkg;

  localparam int GA_POP_SIZE_DEF  = 50;
  localparam int GA_PATH_BITS_DEF = 150;

  typedef logic [2:0] ga_state_t;

  localparam ga_state_t ST_IDLE   = 3'd0;
  localparam ga_state_t ST_INIT   = 3'd1;
  localparam ga_state_t ST_SELECT = 3'd2;
  localparam ga_state_t ST_MUTATE = 3'd3;
  localparam ga_state_t ST_REPORT = 3'd4;
  localparam ga_state_t ST_DONE   = 3'd5;
  localparam ga_state_t ST_ERROR  = 3'd6;

  // Flattened population width in bits.
  function automatic int ga_pop_width(input int pop_size, input int path_bits);
    ga_pop_width = pop_size * path_bits;
  endfunction

  // States in which an external stage is running under timeout supervision.
  function automatic logic ga_is_stage(input ga_state_t st);
    ga_is_stage = (st == ST_INIT) || (st == ST_SELECT) ||
                  (st == ST_MUTATE) || (st == ST_REPORT);
  endfunction

endpackage

// File: rtl/ga_stage_timer.sv
// ga_stage_timer: per-stage watchdog counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : force count to 0 (has priority over en_i)
//   en_i        : count up by one this cycle
//   timeout_o   : count has reached TIMEOUT_CYCLES
// The count saturates at TIMEOUT_CYCLES so the flag cannot drop back by wrap.
module ga_stage_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = (count_q == LIMIT);

endmodule

// File: rtl/ga_run_sequencer.sv
// ga_run_sequencer: generation sequencer for the genetic path search.
// Drives init -> (select -> mutate) x N -> report through single-cycle start
// pulses and done handshakes, owns the working population, and watches each
// stage with a timeout.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : run request (accepted in IDLE/DONE/ERROR)
//   abort                      : level, returns to IDLE (highest priority)
//   num_generations            : generation limit, 0 is treated as 1
//   init_pop, mut_pop          : populations from initializer / mutation
//   *_done                     : stage completion pulses
//   population                 : working population register
//   *_start                    : single-cycle stage start pulses
//   generation                 : generations completed in this run
//   prg_seed                   : free-running seed counter
//   busy, error, state_out     : run status
module ga_run_sequencer
  import ga_pkg::*;
#(
  parameter int POP_SIZE       = GA_POP_SIZE_DEF,
  parameter int PATH_BITS      = GA_PATH_BITS_DEF,
  parameter int GEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int SEED_W         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [GEN_W-1:0]              num_generations,
  input  logic [POP_SIZE*PATH_BITS-1:0] init_pop,
  input  logic [POP_SIZE*PATH_BITS-1:0] mut_pop,
  input  logic                          init_done,
  input  logic                          sel_done,
  input  logic                          mut_done,
  input  logic                          report_done,
  output logic [POP_SIZE*PATH_BITS-1:0] population,
  output logic                          init_start,
  output logic                          sel_start,
  output logic                          mut_start,
  output logic                          report_start,
  output logic [GEN_W-1:0]              generation,
  output logic [SEED_W-1:0]             prg_seed,
  output logic                          busy,
  output logic                          error,
  output logic [2:0]                    state_out
);

  localparam int POP_W = ga_pop_width(POP_SIZE, PATH_BITS);
  localparam logic [GEN_W-1:0]  GEN_ZERO = GEN_W'(0);
  localparam logic [GEN_W-1:0]  GEN_ONE  = GEN_W'(1);
  localparam logic [SEED_W-1:0] SEED_ONE = SEED_W'(1);

  ga_state_t        state_q, state_d;
  logic [POP_W-1:0] pop_q, pop_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [GEN_W-1:0] limit_q, limit_d;
  logic [GEN_W-1:0] gen_inc_s;
  logic [SEED_W-1:0] seed_q;
  logic init_start_q, sel_start_q, mut_start_q, report_start_q;
  logic busy_q, error_q;
  logic first_s, timeout_s, tmr_clr_s, tmr_en_s;

  // A done seen in the same cycle as the stage's start pulse belongs to a
  // previous transaction and must not be taken.
  assign first_s   = init_start_q | sel_start_q | mut_start_q | report_start_q;
  assign gen_inc_s = gen_q + GEN_ONE;

  // Timer restarts on every state change, so it reads 0 on the start cycle.
  assign tmr_clr_s = (state_d != state_q);
  assign tmr_en_s  = ga_is_stage(state_q);

  ga_stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .timeout_o(timeout_s)
  );

  // Next-state, population, generation and limit selection.
  always_comb begin
    state_d = state_q;
    pop_d   = pop_q;
    gen_d   = gen_q;
    limit_d = limit_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            limit_d = (num_generations == GEN_ZERO) ? GEN_ONE : num_generations;
            gen_d   = GEN_ZERO;
            state_d = ST_INIT;
          end else begin
            state_d = state_q;
          end
        end
        ST_INIT: begin
          if (init_done && !first_s) begin
            pop_d   = init_pop;
            state_d = ST_SELECT;
          end else if (timeout_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = state_q;
          end
        end
        ST_SELECT: begin
          if (sel_done && !first_s) begin
            state_d = ST_MUTATE;
          end else if (timeout_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = state_q;
          end
        end
        ST_MUTATE: begin
          if (mut_done && !first_s) begin
            pop_d   = mut_pop;
            gen_d   = gen_inc_s;
            state_d = (gen_inc_s == limit_q) ? ST_REPORT : ST_SELECT;
          end else if (timeout_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = state_q;
          end
        end
        ST_REPORT: begin
          if (report_done && !first_s) begin
            state_d = ST_DONE;
          end else if (timeout_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status/start outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pop_q          <= '0;
      gen_q          <= '0;
      limit_q        <= '0;
      seed_q         <= '0;
      init_start_q   <= 1'b0;
      sel_start_q    <= 1'b0;
      mut_start_q    <= 1'b0;
      report_start_q <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pop_q          <= pop_d;
      gen_q          <= gen_d;
      limit_q        <= limit_d;
      seed_q         <= seed_q + SEED_ONE;
      // Pulse only on the transition into the stage state.
      init_start_q   <= (state_d == ST_INIT)   && (state_q != ST_INIT);
      sel_start_q    <= (state_d == ST_SELECT) && (state_q != ST_SELECT);
      mut_start_q    <= (state_d == ST_MUTATE) && (state_q != ST_MUTATE);
      report_start_q <= (state_d == ST_REPORT) && (state_q != ST_REPORT);
      busy_q         <= ga_is_stage(state_d);
      error_q        <= (state_d == ST_ERROR);
    end
  end

  assign population   = pop_q;
  assign init_start   = init_start_q;
  assign sel_start    = sel_start_q;
  assign mut_start    = mut_start_q;
  assign report_start = report_start_q;
  assign generation   = gen_q;
  assign prg_seed     = seed_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_ga_run_sequencer.sv
// Directed self-checking bench for ga_run_sequencer (POP_SIZE=4, PATH_BITS=8,
// GEN_W=4, TIMEOUT_CYCLES=16). Inputs change 1 time unit after a rising edge,
// outputs are sampled at the same point.
module tb_ga_run_sequencer;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n;
  logic        start, abort;
  logic [3:0]  num_generations;
  logic [31:0] init_pop, mut_pop;
  logic        init_done, sel_done, mut_done, report_done;
  logic [31:0] population;
  logic        init_start, sel_start, mut_start, report_start;
  logic [3:0]  generation;
  logic [31:0] prg_seed;
  logic        busy, error;
  logic [2:0]  state_out;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    mut_cnt = 0;
  string seq_log = "";

  ga_run_sequencer #(
    .POP_SIZE(4), .PATH_BITS(8), .GEN_W(4), .TIMEOUT_CYCLES(16), .SEED_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_generations(num_generations), .init_pop(init_pop), .mut_pop(mut_pop),
    .init_done(init_done), .sel_done(sel_done), .mut_done(mut_done),
    .report_done(report_done), .population(population),
    .init_start(init_start), .sel_start(sel_start), .mut_start(mut_start),
    .report_start(report_start), .generation(generation), .prg_seed(prg_seed),
    .busy(busy), .error(error), .state_out(state_out)
  );

  // Gateable clock so reset can be exercised with the clock stopped.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Record every start pulse as a letter: I, S, M, R.
  always @(negedge clk) begin
    if (init_start)   seq_log = {seq_log, "I"};
    if (sel_start)    seq_log = {seq_log, "S"};
    if (mut_start)    seq_log = {seq_log, "M"};
    if (report_start) seq_log = {seq_log, "R"};
  end

  // Stage responder: returns each done dly cycles after its start pulse.
  // Stops on DONE/ERROR, on the abort trigger, or when max_cyc expires.
  task automatic respond(input int dly, input bit hold_sel, input int abort_gen,
                         input int max_cyc, output int sel_cyc, output int err_cyc);
    int ci, cs, cm, cr, cyc;
    ci = -1; cs = -1; cm = -1; cr = -1; cyc = 0; sel_cyc = -1; err_cyc = -1;
    while (cyc < max_cyc) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0; init_done = 1'b0; sel_done = 1'b0; mut_done = 1'b0; report_done = 1'b0;
      if (state_out == 3'd5) break;
      if (state_out == 3'd6) begin err_cyc = cyc; break; end
      if (abort_gen >= 0 && mut_start && int'(generation) == abort_gen) begin
        abort = 1'b1;
        break;
      end
      if (init_start) ci = dly; else if (ci > 0) ci--;
      if (ci == 0) begin init_done = 1'b1; ci = -1; end
      if (sel_start) begin cs = hold_sel ? -1 : dly; sel_cyc = cyc; end
      else if (cs > 0) cs--;
      if (cs == 0) begin sel_done = 1'b1; cs = -1; end
      if (mut_start) cm = dly; else if (cm > 0) cm--;
      if (cm == 0) begin
        mut_cnt++;
        mut_pop = 32'hA5A5_0000 + 32'(mut_cnt);
        mut_done = 1'b1; cm = -1;
      end
      if (report_start) cr = dly; else if (cr > 0) cr--;
      if (cr == 0) begin report_done = 1'b1; cr = -1; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_generations = 4'd0;
    init_pop = 32'h0; mut_pop = 32'h0;
    init_done = 1'b0; sel_done = 1'b0; mut_done = 1'b0; report_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({state_out, busy, error, generation} !== 9'd0) begin n_bad++;
      $display("FAIL reset_status: got st=%0d busy=%0b err=%0b gen=%0d want all 0", state_out, busy, error, generation); end
    n_cmp++; if (population !== 32'h0) begin n_bad++;
      $display("FAIL reset_pop: got %h want 0", population); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (prg_seed !== 32'd0) begin n_bad++; $display("FAIL seed0: got %0d want 0", prg_seed); end
    @(posedge clk); #1;
    n_cmp++; if (prg_seed !== 32'd1) begin n_bad++; $display("FAIL seed1: got %0d want 1", prg_seed); end
    @(posedge clk); #1;
    n_cmp++; if (prg_seed !== 32'd2) begin n_bad++; $display("FAIL seed2: got %0d want 2", prg_seed); end
  endtask

  task automatic test_nominal();
    int sc, ec;
    seq_log = ""; mut_cnt = 0;
    num_generations = 4'd3; init_pop = 32'h1122_3344;
    start = 1'b1;
    respond(3, 1'b0, -1, 300, sc, ec);
    n_cmp++; if (seq_log != "ISMSMSMR") begin n_bad++;
      $display("FAIL nom_seq: got %s want ISMSMSMR", seq_log); end
    n_cmp++; if (generation !== 4'd3) begin n_bad++; $display("FAIL nom_gen: got %0d want 3", generation); end
    n_cmp++; if (population !== 32'hA5A5_0003) begin n_bad++;
      $display("FAIL nom_pop: got %h want a5a50003", population); end
    n_cmp++; if (state_out !== 3'd5 || busy !== 1'b0 || error !== 1'b0) begin n_bad++;
      $display("FAIL nom_done: got st=%0d busy=%0b err=%0b want st=5 busy=0 err=0", state_out, busy, error); end
  endtask

  task automatic test_gen_zero();
    int sc, ec;
    seq_log = ""; mut_cnt = 0;
    num_generations = 4'd0;
    start = 1'b1;
    respond(3, 1'b0, -1, 200, sc, ec);
    n_cmp++; if (seq_log != "ISMR") begin n_bad++; $display("FAIL zero_seq: got %s want ISMR", seq_log); end
    n_cmp++; if (generation !== 4'd1 || state_out !== 3'd5) begin n_bad++;
      $display("FAIL zero_end: got gen=%0d st=%0d want gen=1 st=5", generation, state_out); end
    n_cmp++; if (population !== 32'hA5A5_0001) begin n_bad++;
      $display("FAIL zero_pop: got %h want a5a50001", population); end
  endtask

  task automatic test_timeout();
    int sc, ec;
    seq_log = ""; mut_cnt = 0;
    num_generations = 4'd2; init_pop = 32'h0BAD_F00D;
    start = 1'b1;
    respond(3, 1'b1, -1, 100, sc, ec);
    n_cmp++; if (ec - sc != 17) begin n_bad++;
      $display("FAIL to_latency: got %0d cycles (sel=%0d err=%0d) want 17", ec - sc, sc, ec); end
    n_cmp++; if (error !== 1'b1 || state_out !== 3'd6 || busy !== 1'b0) begin n_bad++;
      $display("FAIL to_status: got err=%0b st=%0d busy=%0b want err=1 st=6 busy=0", error, state_out, busy); end
    n_cmp++; if (population !== 32'h0BAD_F00D || generation !== 4'd0) begin n_bad++;
      $display("FAIL to_hold: got pop=%h gen=%0d want 0badf00d/0", population, generation); end
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n_cmp++; if (state_out !== 3'd1 || init_start !== 1'b1 || generation !== 4'd0 || error !== 1'b0) begin n_bad++;
      $display("FAIL to_restart: got st=%0d istart=%0b gen=%0d err=%0b want 1/1/0/0", state_out, init_start, generation, error); end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    n_cmp++; if (state_out !== 3'd0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL to_abort: got st=%0d busy=%0b want 0/0", state_out, busy); end
  endtask

  task automatic test_abort();
    int sc, ec;
    seq_log = ""; mut_cnt = 0;
    num_generations = 4'd3; init_pop = 32'h1357_9BDF;
    start = 1'b1;
    respond(3, 1'b0, 1, 200, sc, ec);
    @(posedge clk); #1; abort = 1'b0;
    n_cmp++; if (state_out !== 3'd0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL ab_idle: got st=%0d busy=%0b want 0/0", state_out, busy); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (seq_log != "ISMSM") begin n_bad++; $display("FAIL ab_seq: got %s want ISMSM", seq_log); end
    n_cmp++; if (generation !== 4'd1 || population !== 32'hA5A5_0001) begin n_bad++;
      $display("FAIL ab_hold: got gen=%0d pop=%h want 1/a5a50001", generation, population); end
  endtask

  task automatic test_stray();
    num_generations = 4'd1; init_pop = 32'hCAFE_0001;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n_cmp++; if (state_out !== 3'd1 || init_start !== 1'b1) begin n_bad++;
      $display("FAIL st_init: got st=%0d istart=%0b want 1/1", state_out, init_start); end
    init_done = 1'b1; @(posedge clk); #1;
    n_cmp++; if (state_out !== 3'd1) begin n_bad++; $display("FAIL st_init_first: got st=%0d want 1", state_out); end
    @(posedge clk); #1; init_done = 1'b0;
    n_cmp++; if (state_out !== 3'd2 || sel_start !== 1'b1 || population !== 32'hCAFE_0001) begin n_bad++;
      $display("FAIL st_sel: got st=%0d sstart=%0b pop=%h want 2/1/cafe0001", state_out, sel_start, population); end
    sel_done = 1'b1; mut_done = 1'b1; @(posedge clk); #1; sel_done = 1'b0;
    n_cmp++; if (state_out !== 3'd2) begin n_bad++; $display("FAIL st_sel_first: got st=%0d want 2", state_out); end
    @(posedge clk); #1; mut_done = 1'b0;
    n_cmp++; if (state_out !== 3'd2 || generation !== 4'd0) begin n_bad++;
      $display("FAIL st_stray_mut: got st=%0d gen=%0d want 2/0", state_out, generation); end
    sel_done = 1'b1; @(posedge clk); #1; sel_done = 1'b0;
    n_cmp++; if (state_out !== 3'd3 || mut_start !== 1'b1) begin n_bad++;
      $display("FAIL st_mut: got st=%0d mstart=%0b want 3/1", state_out, mut_start); end
    repeat (16) @(posedge clk);
    #1;
    n_cmp++; if (state_out !== 3'd3 || error !== 1'b0) begin n_bad++;
      $display("FAIL st_mut_wait: got st=%0d err=%0b want 3/0", state_out, error); end
    mut_done = 1'b1; mut_pop = 32'hDEAD_BEEF; @(posedge clk); #1; mut_done = 1'b0;
    n_cmp++; if (state_out !== 3'd4 || report_start !== 1'b1 || generation !== 4'd1 || error !== 1'b0) begin n_bad++;
      $display("FAIL st_race: got st=%0d rstart=%0b gen=%0d err=%0b want 4/1/1/0", state_out, report_start, generation, error); end
    n_cmp++; if (population !== 32'hDEAD_BEEF) begin n_bad++;
      $display("FAIL st_race_pop: got %h want deadbeef", population); end
    report_done = 1'b1; @(posedge clk); #1; @(posedge clk); #1; report_done = 1'b0;
    n_cmp++; if (state_out !== 3'd5 || busy !== 1'b0) begin n_bad++;
      $display("FAIL st_done: got st=%0d busy=%0b want 5/0", state_out, busy); end
  endtask

  task automatic test_async_reset();
    num_generations = 4'd3; init_pop = 32'h7777_1111;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; init_done = 1'b1;
    @(posedge clk); #1; init_done = 1'b0;
    n_cmp++; if (state_out !== 3'd2) begin n_bad++; $display("FAIL ar_sel: got st=%0d want 2", state_out); end
    start = 1'b1; num_generations = 4'd7; @(posedge clk); #1; start = 1'b0;
    n_cmp++; if (state_out !== 3'd2 || init_start !== 1'b0 || generation !== 4'd0) begin n_bad++;
      $display("FAIL ar_busy_start: got st=%0d istart=%0b gen=%0d want 2/0/0", state_out, init_start, generation); end
    @(negedge clk); #1; clk_en = 1'b0;
    #3; rst_n = 1'b0; #1;
    n_cmp++; if ({state_out, busy, error, generation, init_start, sel_start, mut_start, report_start} !== 13'd0) begin n_bad++;
      $display("FAIL ar_status: got st=%0d busy=%0b err=%0b gen=%0d starts=%0b%0b%0b%0b want all 0",
               state_out, busy, error, generation, init_start, sel_start, mut_start, report_start); end
    n_cmp++; if (population !== 32'h0 || prg_seed !== 32'd0) begin n_bad++;
      $display("FAIL ar_data: got pop=%h seed=%0d want 0/0", population, prg_seed); end
    #2; rst_n = 1'b1; #2; clk_en = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (prg_seed !== 32'd1 || state_out !== 3'd0) begin n_bad++;
      $display("FAIL ar_release: got seed=%0d st=%0d want 1/0", prg_seed, state_out); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gen_zero();
    test_timeout();
    test_abort();
    test_stray();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
